// File: rtl/reg_scoreboard_file.sv
// Issue-stage register file with in-use scoreboard: hazard check, reservation, registered operands.
// Optional macro WB_BYPASS_EN forwards same-cycle write-back data to sources instead of stalling.
module reg_scoreboard_file #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [ADDR_W-1:0]   iss_src1,
  input  logic                iss_src1_vld,
  input  logic [ADDR_W-1:0]   iss_src2,
  input  logic                iss_src2_vld,
  input  logic [ADDR_W-1:0]   iss_dst,
  input  logic                iss_dst_vld,
  input  logic [ADDR_W-1:0]   iss_dst2,
  input  logic                iss_dst2_vld,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [DATA_W-1:0]   op_src1_data,
  output logic [DATA_W-1:0]   op_src2_data,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dst,
  input  logic                wb_dst_vld,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic [ADDR_W-1:0]   wb_dst2,
  input  logic                wb_dst2_vld,
  input  logic [DATA_W-1:0]   wb_data2,
  output logic [NUM_REGS-1:0] busy_map,
  output logic                wb_err
);

  logic [DATA_W-1:0]   regFile [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                opValidQ;
  logic [DATA_W-1:0]   opSrc1Q, opSrc2Q;
  logic                wbErrQ;

  logic                wbDstHit, wbDst2Hit;
  logic [NUM_REGS-1:0] wbClr, issSet;
  logic                src1Busy, src2Busy, hazard, fire, wbErrSet;
  logic [DATA_W-1:0]   src1Val, src2Val;

  assign wbDstHit  = wb_valid & wb_dst_vld;
  assign wbDst2Hit = wb_valid & wb_dst2_vld;
  assign wbClr     = (wbDstHit  ? (NUM_REGS'(1) << wb_dst)  : '0)
                   | (wbDst2Hit ? (NUM_REGS'(1) << wb_dst2) : '0);
  assign issSet    = (iss_dst_vld  ? (NUM_REGS'(1) << iss_dst)  : '0)
                   | (iss_dst2_vld ? (NUM_REGS'(1) << iss_dst2) : '0);

`ifdef WB_BYPASS_EN
  // A source being released this cycle is satisfied by the forwarded result.
  assign src1Busy = busy[iss_src1] & ~wbClr[iss_src1];
  assign src2Busy = busy[iss_src2] & ~wbClr[iss_src2];
`else
  assign src1Busy = busy[iss_src1];
  assign src2Busy = busy[iss_src2];
`endif

  assign hazard = (iss_src1_vld & src1Busy) | (iss_src2_vld & src2Busy)
                | (iss_dst_vld & busy[iss_dst]) | (iss_dst2_vld & busy[iss_dst2]);
  assign iss_ready = ~hazard & (~opValidQ | op_ready);
  assign fire      = iss_valid & iss_ready;
  assign wbErrSet  = (wbDstHit & ~busy[wb_dst]) | (wbDst2Hit & ~busy[wb_dst2]);

  function automatic logic [DATA_W-1:0] readOperand(input logic [ADDR_W-1:0] idx,
                                                    input logic vld);
    logic [DATA_W-1:0] val;
    val = regFile[idx];
`ifdef WB_BYPASS_EN
    if (wbDst2Hit && wb_dst2 == idx) val = wb_data2;
    if (wbDstHit && wb_dst == idx)   val = wb_data;
`endif
    return vld ? val : '0;
  endfunction

  assign src1Val = readOperand(iss_src1, iss_src1_vld);
  assign src2Val = readOperand(iss_src2, iss_src2_vld);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
      busy     <= '0;
      opValidQ <= 1'b0;
      opSrc1Q  <= '0;
      opSrc2Q  <= '0;
      wbErrQ   <= 1'b0;
    end else begin
      // Reservation is applied after release so a same-edge reserve wins.
      busy   <= (busy & ~wbClr) | (fire ? issSet : '0);
      wbErrQ <= wbErrQ | wbErrSet;
      if (wbDst2Hit) regFile[wb_dst2] <= wb_data2;
      if (wbDstHit)  regFile[wb_dst]  <= wb_data;
      if (fire) begin
        opValidQ <= 1'b1;
        opSrc1Q  <= src1Val;
        opSrc2Q  <= src2Val;
      end else if (op_ready) begin
        opValidQ <= 1'b0;
      end
    end
  end

  assign op_valid     = opValidQ;
  assign op_src1_data = opSrc1Q;
  assign op_src2_data = opSrc2Q;
  assign busy_map     = busy;
  assign wb_err       = wbErrQ;

endmodule
